led_pattern_gen: RTL and testbench

Parametrised LED sequencer: it drives `NUM_LED` outputs with one of four selectable patterns, stepping at a programmable rate derived from `sys_clk`. It is the generalised replacement for the fixed 3-LED rotator. It sits directly on the board LED pins, and its `step_pulse` output lets other logic synchronise to pattern steps.

---
 rtl/led_pattern_gen.sv | 182 ++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//
// Parametrised LED sequencer. Drives NUM_LED board pins with one of four
// patterns (rotate-left, rotate-right, bounce, blink-all) and advances the
// pattern once every `limit` clock cycles, where
// limit = max(1, TICK_CYCLES >> speed).
//
// Parameters:
//   NUM_LED      number of LED outputs (>= 1)
//   TICK_CYCLES  clock cycles per step at speed = 0
//   ACTIVE_LOW   1 = a low pin lights the LED, 0 = active-high pins
//
// Ports:
//   sys_clk     in   single clock, all logic on the rising edge
//   sys_rst_n   in   synchronous active-low reset
//   mode        in   00 rotate-left, 01 rotate-right, 10 bounce, 11 blink-all
//   speed       in   step period selector (TICK_CYCLES >> speed, min 1)
//   pause       in   1 freezes counter, pattern and bounce direction
//   led         out  LED drive, polarity set by ACTIVE_LOW
//   step_pulse  out  one-cycle strobe on every pattern step
// ---------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int NUM_LED     = 3,
  parameter int TICK_CYCLES = 13_500_000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               pause,
  output logic [NUM_LED-1:0] led,
  output logic               step_pulse
);

  localparam int CNT_W = (TICK_CYCLES < 1) ? 1 : $clog2(TICK_CYCLES + 1);

  // Terminal count (limit - 1) for a given speed shift, clamped so that
  // a very fast speed never yields a zero-length period.
  function automatic logic [CNT_W-1:0] limit_m1_for(input int shift);
    int lim;
    lim = TICK_CYCLES >> shift;
    if (lim < 1) begin
      lim = 1;
    end
    return CNT_W'(lim - 1);
  endfunction

  localparam logic [CNT_W-1:0] LIM_M1_S0 = limit_m1_for(0);
  localparam logic [CNT_W-1:0] LIM_M1_S1 = limit_m1_for(1);
  localparam logic [CNT_W-1:0] LIM_M1_S2 = limit_m1_for(2);
  localparam logic [CNT_W-1:0] LIM_M1_S3 = limit_m1_for(3);

  localparam logic [NUM_LED-1:0] PAT_ONE = NUM_LED'(1);

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'b00,
    MODE_ROT_R  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [CNT_W-1:0]   cnt_q,  cnt_n;
  logic [NUM_LED-1:0] pat_q,  pat_n;
  dir_t               dir_q,  dir_n;
  mode_t              mode_q, mode_n;
  logic               step_q, step_n;

  logic [CNT_W-1:0]   limit_m1;
  logic [NUM_LED-1:0] pat_shl, pat_shr, pat_rot_l, pat_rot_r;
  logic [NUM_LED-1:0] pat_step;
  dir_t               dir_step;
  logic               mode_change;
  logic               step_due;

  // Terminal count for the currently selected speed.
  always_comb begin
    limit_m1 = LIM_M1_S0;
    case (speed)
      2'd0:    limit_m1 = LIM_M1_S0;
      2'd1:    limit_m1 = LIM_M1_S1;
      2'd2:    limit_m1 = LIM_M1_S2;
      default: limit_m1 = LIM_M1_S3;
    endcase
  end

  // Shift and rotate building blocks. The rotate forms OR the wrapped bit
  // back in with a shift, which also works for NUM_LED = 1 (pattern holds).
  assign pat_shl   = pat_q << 1;
  assign pat_shr   = pat_q >> 1;
  assign pat_rot_l = (pat_q << 1) | (pat_q >> (NUM_LED - 1));
  assign pat_rot_r = (pat_q >> 1) | (pat_q << (NUM_LED - 1));

  // Pattern and bounce direction after one step in the registered mode.
  // Bounce flips direction on the step that lands on an endpoint so the
  // endpoint is shown once, giving a 2N-2 step period.
  always_comb begin
    pat_step = pat_q;
    dir_step = dir_q;
    case (mode_q)
      MODE_ROT_L: pat_step = pat_rot_l;
      MODE_ROT_R: pat_step = pat_rot_r;
      MODE_BOUNCE: begin
        if (NUM_LED > 1) begin
          if (dir_q == DIR_UP) begin
            pat_step = pat_shl;
            if (pat_shl[NUM_LED-1]) begin
              dir_step = DIR_DOWN;
            end
          end else begin
            pat_step = pat_shr;
            if (pat_shr[0]) begin
              dir_step = DIR_UP;
            end
          end
        end
      end
      MODE_BLINK: pat_step = ~pat_q;
      default:    pat_step = pat_q;
    endcase
  end

  // ">=" rather than "==" so that switching to a faster speed mid-count
  // steps on the next edge instead of waiting for the counter to wrap.
  assign mode_change = (mode_t'(mode) != mode_q);
  assign step_due    = (cnt_q >= limit_m1);

  // Next-state selection. A mode change is honoured even while paused and
  // wins over a step that would otherwise fire on the same edge.
  always_comb begin
    cnt_n  = cnt_q;
    pat_n  = pat_q;
    dir_n  = dir_q;
    mode_n = mode_q;
    step_n = 1'b0;
    if (mode_change) begin
      mode_n = mode_t'(mode);
      cnt_n  = '0;
      pat_n  = (mode_t'(mode) == MODE_BLINK) ? '1 : PAT_ONE;
      dir_n  = DIR_UP;
    end else if (!pause) begin
      if (step_due) begin
        cnt_n  = '0;
        pat_n  = pat_step;
        dir_n  = dir_step;
        step_n = 1'b1;
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers. Reset captures the current mode so that the first
  // edge after release is not mistaken for a mode change.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      pat_q  <= PAT_ONE;
      dir_q  <= DIR_UP;
      mode_q <= mode_t'(mode);
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_n;
      pat_q  <= pat_n;
      dir_q  <= dir_n;
      mode_q <= mode_n;
      step_q <= step_n;
    end
  end

  // Outputs come straight from the registers; ACTIVE_LOW is a constant so
  // this is either a plain wire or a bank of inverters.
  assign led        = ACTIVE_LOW ? ~pat_q : pat_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Three instances share one stimulus stream: 3 LEDs active-low, 4 LEDs
// active-high and a single LED. A reference model tracks the pattern as
// "number of steps since the last reload" and derives the lit position
// arithmetically; each cycle's expected outputs are queued and a separate
// monitor pops and compares them one cycle later.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int TICK = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;

  logic [2:0] led3;
  logic [3:0] led4;
  logic [0:0] led1;
  logic       step3, step4, step1;

  always #5 sys_clk = ~sys_clk;

  led_pattern_gen #(.NUM_LED(3), .TICK_CYCLES(TICK), .ACTIVE_LOW(1'b1)) dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode), .speed(speed),
    .pause(pause), .led(led3), .step_pulse(step3)
  );

  led_pattern_gen #(.NUM_LED(4), .TICK_CYCLES(TICK), .ACTIVE_LOW(1'b0)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode), .speed(speed),
    .pause(pause), .led(led4), .step_pulse(step4)
  );

  led_pattern_gen #(.NUM_LED(1), .TICK_CYCLES(TICK), .ACTIVE_LOW(1'b0)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode), .speed(speed),
    .pause(pause), .led(led1), .step_pulse(step1)
  );

  typedef struct {
    bit         pulse;
    logic [2:0] led3;
    logic [3:0] led4;
    logic [0:0] led1;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int m_mode;
  int m_k;
  int m_elapsed;
  bit m_base_ones;
  bit m_pulse;

  // Lit vector after k steps since the last reload, for an n-LED sequencer.
  function automatic int exp_pat(input int n, input int md, input int k, input bit base_ones);
    int all, pos, p, base;
    all = (1 << n) - 1;
    case (md)
      0: begin
        pos = k % n;
        return 1 << pos;
      end
      1: begin
        pos = (n - (k % n)) % n;
        return 1 << pos;
      end
      2: begin
        if (n == 1) return 1;
        p   = k % (2 * n - 2);
        pos = (p < n) ? p : (2 * n - 2 - p);
        return 1 << pos;
      end
      default: begin
        base = base_ones ? all : 1;
        return ((k % 2) == 0) ? base : (~base & all);
      end
    endcase
  endfunction

  task automatic modelStep(input bit rst_n_i, input int md, input int spd, input bit ps);
    int lim;
    m_pulse = 1'b0;
    if (!rst_n_i) begin
      m_mode      = md;
      m_k         = 0;
      m_base_ones = 1'b0;
      m_elapsed   = 0;
    end else if (md != m_mode) begin
      m_mode      = md;
      m_k         = 0;
      m_base_ones = (md == 3);
      m_elapsed   = 0;
    end else if (!ps) begin
      lim = TICK >> spd;
      if (lim < 1) lim = 1;
      if (m_elapsed + 1 >= lim) begin
        m_elapsed = 0;
        m_k++;
        m_pulse = 1'b1;
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), predict the outcome of
  // the coming edge, and queue the prediction once that edge has happened.
  task automatic applyStimulus(input bit rst_n_i, input logic [1:0] md, input logic [1:0] spd, input bit ps);
    exp_t e;
    sys_rst_n = rst_n_i;
    mode      = md;
    speed     = spd;
    pause     = ps;
    modelStep(rst_n_i, int'(md), int'(spd), ps);
    e.pulse = m_pulse;
    e.led3  = 3'(~exp_pat(3, m_mode, m_k, m_base_ones));
    e.led4  = 4'(exp_pat(4, m_mode, m_k, m_base_ones));
    e.led1  = 1'(exp_pat(1, m_mode, m_k, m_base_ones));
    @(posedge sys_clk);
    sb_q.push_back(e);
    #1;
  endtask

  // Monitor: compares every registered output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("sb_step3", 32'(step3), 32'(e.pulse));
        checkOutput("sb_step4", 32'(step4), 32'(e.pulse));
        checkOutput("sb_step1", 32'(step1), 32'(e.pulse));
        checkOutput("sb_led3",  32'(led3),  32'(e.led3));
        checkOutput("sb_led4",  32'(led4),  32'(e.led4));
        checkOutput("sb_led1",  32'(led1),  32'(e.led1));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    logic [1:0] r_mode, r_speed;
    bit r_pause;
    sys_rst_n = 1'b0;
    mode      = 2'b00;
    speed     = 2'd0;
    pause     = 1'b0;
    #1;

    // Reset held for three edges, then the rotate-left sequence on 3 LEDs
    repeat (3) applyStimulus(1'b0, 2'b00, 2'd0, 1'b0);
    checkOutput("reset_led3",  32'(led3),  32'(3'b110));
    checkOutput("reset_step3", 32'(step3), 32'd0);
    checkOutput("reset_led4",  32'(led4),  32'(4'b0001));
    repeat (7) applyStimulus(1'b1, 2'b00, 2'd0, 1'b0);
    checkOutput("first_step_early", 32'(step3), 32'd0);
    applyStimulus(1'b1, 2'b00, 2'd0, 1'b0);
    checkOutput("first_step_led3",  32'(led3),  32'(3'b101));
    checkOutput("first_step_pulse", 32'(step3), 32'd1);
    applyStimulus(1'b1, 2'b00, 2'd0, 1'b0);
    checkOutput("pulse_one_cycle",  32'(step3), 32'd0);
    repeat (7) applyStimulus(1'b1, 2'b00, 2'd0, 1'b0);
    checkOutput("second_step_led3", 32'(led3), 32'(3'b011));
    repeat (8) applyStimulus(1'b1, 2'b00, 2'd0, 1'b0);
    checkOutput("third_step_led3",  32'(led3), 32'(3'b110));

    // Rotate-right then bounce
    applyStimulus(1'b1, 2'b01, 2'd0, 1'b0);
    repeat (8) applyStimulus(1'b1, 2'b01, 2'd0, 1'b0);
    checkOutput("rotr_first_led4", 32'(led4), 32'(4'b1000));
    repeat (40) applyStimulus(1'b1, 2'b01, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'd0, 1'b0);
    repeat (24) applyStimulus(1'b1, 2'b10, 2'd0, 1'b0);
    checkOutput("bounce_top_led4", 32'(led4), 32'(4'b1000));
    repeat (40) applyStimulus(1'b1, 2'b10, 2'd0, 1'b0);

    // Speed: period 2, then a mid-count switch to the fastest rate
    repeat (20) applyStimulus(1'b1, 2'b10, 2'd2, 1'b0);
    for (int i = 0; i < 20 && m_elapsed != 5; i++) applyStimulus(1'b1, 2'b10, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'd3, 1'b0);
    checkOutput("speed_switch_step", 32'(step4), 32'd1);
    applyStimulus(1'b1, 2'b10, 2'd3, 1'b0);
    checkOutput("speed_every_edge", 32'(step4), 32'd1);
    repeat (10) applyStimulus(1'b1, 2'b10, 2'd3, 1'b0);

    // Pause at counter 3 for ten cycles
    for (int i = 0; i < 20 && m_elapsed != 3; i++) applyStimulus(1'b1, 2'b10, 2'd0, 1'b0);
    repeat (10) applyStimulus(1'b1, 2'b10, 2'd0, 1'b1);
    gap = -1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 2'b10, 2'd0, 1'b0);
      if (step4 && gap < 0) gap = i;
    end
    checkOutput("pause_resume_gap", 32'(gap), 32'd5);

    // Mode change 00 -> 11 mid-count, then reset in the middle of blinking
    applyStimulus(1'b1, 2'b00, 2'd0, 1'b0);
    for (int i = 0; i < 20 && m_elapsed != 4; i++) applyStimulus(1'b1, 2'b00, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'b11, 2'd0, 1'b0);
    checkOutput("blink_all_on_led3", 32'(led3), 32'(3'b000));
    checkOutput("blink_all_on_led4", 32'(led4), 32'(4'b1111));
    repeat (8) applyStimulus(1'b1, 2'b11, 2'd0, 1'b0);
    checkOutput("blink_all_off_led3", 32'(led3), 32'(3'b111));
    repeat (3) applyStimulus(1'b1, 2'b11, 2'd0, 1'b0);
    applyStimulus(1'b0, 2'b11, 2'd0, 1'b0);
    checkOutput("midblink_reset_led3", 32'(led3), 32'(3'b110));
    repeat (20) applyStimulus(1'b1, 2'b11, 2'd0, 1'b0);

    // Randomised traffic
    r_mode  = 2'b11;
    r_speed = 2'd0;
    r_pause = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) r_mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) r_speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) r_pause = ~r_pause;
      applyStimulus(($urandom_range(0, 99) >= 2), r_mode, r_speed, r_pause);
    end

    #5;
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
